// File: rtl/secded_scrub_ctrl_if.sv
// Host and memory bus bundle for secded_scrub_ctrl.
// slave = controller side, master = host/memory side.
interface secded_scrub_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic              host_ready;
  logic              host_wack;
  logic              host_rvalid;
  logic [31:0]       host_rdata;
  logic              host_err_single;
  logic              host_err_double;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [38:0]       mem_wdata;
  logic [38:0]       mem_rdata;

  modport slave (
    input  host_req,
    input  host_we,
    input  host_addr,
    input  host_wdata,
    output host_ready,
    output host_wack,
    output host_rvalid,
    output host_rdata,
    output host_err_single,
    output host_err_double,
    output mem_addr,
    output mem_re,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport master (
    output host_req,
    output host_we,
    output host_addr,
    output host_wdata,
    input  host_ready,
    input  host_wack,
    input  host_rvalid,
    input  host_rdata,
    input  host_err_single,
    input  host_err_double,
    input  mem_addr,
    input  mem_re,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/secded_scrub_ctrl.sv
// SECDED memory sequencer: host arbitration, background scrub,
// single-error writeback and double-error logging.

module secded_enc (
  input  logic [31:0] data,
  output logic [38:0] code
);
  // bit 0 = overall parity, bits 1..38 = Hamming positions
  always_comb begin
    logic [38:0] c;
    logic [5:0]  x;
    int          j;
    c = '0;
    x = '0;
    j = 0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[6'(p)] = data[5'(j)];
        if (data[5'(j)])
          x = x ^ 6'(p);
        j++;
      end
    end
    c[1]  = x[0];
    c[2]  = x[1];
    c[4]  = x[2];
    c[8]  = x[3];
    c[16] = x[4];
    c[32] = x[5];
    c[0]  = ^c[38:1];
    code  = c;
  end
endmodule

module secded_dec (
  input  logic [38:0] code,
  output logic [31:0] data,
  output logic [6:0]  synd
);
  always_comb begin
    logic [38:0] c;
    logic [5:0]  x;
    int          j;
    x = '0;
    for (int p = 1; p < 39; p++) begin
      if (code[6'(p)])
        x = x ^ 6'(p);
    end
    synd = {^code, x};
    c = code;
    if (synd[6] && x != 6'd0 && x < 6'd39)
      c[x] = ~c[x];
    data = '0;
    j = 0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        data[5'(j)] = c[6'(p)];
        j++;
      end
    end
  end
endmodule

module secded_scrub_ctrl #(
  parameter int ADDR_W         = 4,
  parameter int SCRUB_INTERVAL = 64
) (
  input  logic              clk,
  input  logic              rst,
  secded_scrub_ctrl_if.slave bus,
  input  logic              scrub_en,
  output logic [15:0]       corr_count,
  output logic [15:0]       uncorr_count,
  output logic [ADDR_W-1:0] last_err_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;

  localparam int TW = $clog2(SCRUB_INTERVAL);
  localparam logic [TW-1:0] T_LAST =
    TW'(SCRUB_INTERVAL - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic              src_scrub;
  logic [ADDR_W-1:0] scrub_addr;
  logic              scrub_pending;
  logic [TW-1:0]     timer;

  logic [15:0]       corr_q;
  logic [15:0]       uncorr_q;
  logic [ADDR_W-1:0] last_q;

  logic              wack_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic              es_q;
  logic              ed_q;
  logic [ADDR_W-1:0] maddr_q;
  logic              re_q;
  logic              we_q;
  logic [38:0]       wdata_q;

  logic [31:0]       dec_data;
  logic [6:0]        synd;
  logic              is_single;
  logic              is_double;
  logic [31:0]       enc_in;
  logic [38:0]       enc_code;

  secded_dec u_dec (
    .code (bus.mem_rdata),
    .data (dec_data),
    .synd (synd)
  );

  // one encoder: host data in IDLE, corrected data in CHECK
  assign enc_in = (state == S_CHECK) ? dec_data
                                     : bus.host_wdata;

  secded_enc u_enc (
    .data (enc_in),
    .code (enc_code)
  );

  assign is_single = synd[6];
  assign is_double = !synd[6] && (synd[5:0] != 6'd0);

  assign bus.host_ready =
    (state == S_IDLE) && bus.host_req;

  assign bus.host_wack       = wack_q;
  assign bus.host_rvalid     = rvalid_q;
  assign bus.host_rdata      = rdata_q;
  assign bus.host_err_single = es_q;
  assign bus.host_err_double = ed_q;
  assign bus.mem_addr        = maddr_q;
  assign bus.mem_re          = re_q;
  assign bus.mem_we          = we_q;
  assign bus.mem_wdata       = wdata_q;

  assign corr_count    = corr_q;
  assign uncorr_count  = uncorr_q;
  assign last_err_addr = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      src_scrub     <= 1'b0;
      scrub_addr    <= '0;
      scrub_pending <= 1'b0;
      timer         <= '0;
      corr_q        <= '0;
      uncorr_q      <= '0;
      last_q        <= '0;
      wack_q        <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      es_q          <= 1'b0;
      ed_q          <= 1'b0;
      maddr_q       <= '0;
      re_q          <= 1'b0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
    end else begin
      wack_q   <= 1'b0;
      rvalid_q <= 1'b0;
      es_q     <= 1'b0;
      ed_q     <= 1'b0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;

      if (!scrub_en) begin
        timer <= '0;
      end else if (!scrub_pending) begin
        if (timer == T_LAST) begin
          timer         <= '0;
          scrub_pending <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end

      unique case (state)
        S_IDLE: begin
          if (bus.host_req) begin
            addr_q  <= bus.host_addr;
            maddr_q <= bus.host_addr;
            if (bus.host_we) begin
              wdata_q <= enc_code;
              we_q    <= 1'b1;
              wack_q  <= 1'b1;
              state   <= S_WRITE;
            end else begin
              re_q      <= 1'b1;
              src_scrub <= 1'b0;
              state     <= S_READ;
            end
          end else if (scrub_pending && scrub_en) begin
            addr_q    <= scrub_addr;
            maddr_q   <= scrub_addr;
            re_q      <= 1'b1;
            src_scrub <= 1'b1;
            state     <= S_READ;
          end
        end
        S_WRITE: state <= S_IDLE;
        S_READ:  state <= S_CHECK;
        S_CHECK: begin
          if (src_scrub) begin
            scrub_addr    <= scrub_addr + 1'b1;
            scrub_pending <= 1'b0;
          end else begin
            rvalid_q <= 1'b1;
            rdata_q  <= dec_data;
            es_q     <= is_single;
            ed_q     <= is_double;
          end
          if (is_single) begin
            if (corr_q != 16'hFFFF)
              corr_q <= corr_q + 16'd1;
            maddr_q <= addr_q;
            wdata_q <= enc_code;
            we_q    <= 1'b1;
            state   <= S_WB;
          end else begin
            if (is_double) begin
              if (uncorr_q != 16'hFFFF)
                uncorr_q <= uncorr_q + 16'd1;
              last_q <= addr_q;
            end
            state <= S_IDLE;
          end
        end
        S_WB:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/secded_scrub_ctrl.md
# secded_scrub_ctrl

Sequencing controller for a SECDED-protected word memory. It arbitrates host read/write requests against a background scrubber and drives a single-port memory that stores 39-bit codewords. Read data passes through the team's 32-bit SECDED decoder, which has a 7-bit syndrome. Single-bit errors are corrected and written back; double-bit errors are flagged and logged.

## Interface
Parameters:
- ADDR_W, 4: memory address width; depth = 2^ADDR_W words.
- SCRUB_INTERVAL, 64: idle cycles between scrub operations; must be ≥ 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- host_req  in  1  host request; held until accepted.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  word address.
- host_wdata  in  32  write data.
- host_ready  out  1  request accepted this cycle.
- host_wack  out  1  one-cycle pulse when the write reaches memory.
- host_rvalid  out  1  one-cycle pulse when read data is valid.
- host_rdata  out  32  corrected read data.
- host_err_single  out  1  qualifies host_rvalid: a single error was corrected.
- host_err_double  out  1  qualifies host_rvalid: an uncorrectable error occurred.
- scrub_en  in  1  enables the background scrubber.
- mem_addr  out  ADDR_W  memory address.
- mem_re  out  1  memory read strobe; mem_rdata is valid the following cycle.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  39  codeword to write.
- mem_rdata  in  39  codeword read.
- corr_count  out  16  corrected-error count; saturates at 0xFFFF.
- uncorr_count  out  16  uncorrectable-error count; saturates at 0xFFFF.
- last_err_addr  out  ADDR_W  address of the most recent uncorrectable error.

## Operation
- Internal instances: the team SECDED encoder (32→39) and decoder (39→32 + synd[6:0]), both combinational.
- Syndrome classification:
  - synd == 0: clean.
  - synd[6] == 1: single error; dec_data is corrected.
  - synd[6] == 0 and synd[5:0] != 0: double error; dec_data is not trusted.
- States: IDLE, WRITE, READ, CHECK, WB.
- IDLE:
  - host_ready = (state == IDLE) && host_req. The host always wins over a pending scrub.
  - Host write accepted: latch addr/data → WRITE.
  - Host read accepted: latch addr, src = host → READ.
  - Else, if scrub_pending && scrub_en: src = scrub, addr = scrub_addr → READ.
- WRITE: mem_we = 1, mem_wdata = enc(latched data), host_wack = 1 → IDLE.
- READ: mem_re = 1, mem_addr = latched addr → CHECK.
- CHECK: decode mem_rdata.
  - Host source: register host_rvalid, host_rdata, and the flags; they are visible the next cycle.
  - Scrub source: host_* outputs are not driven; scrub_addr increments, wrapping 2^ADDR_W−1 → 0; scrub_pending clears.
  - Single error: corr_count += 1 → WB.
  - Double error: uncorr_count += 1, last_err_addr = addr, no writeback → IDLE.
  - Clean → IDLE.
- WB: mem_we = 1, mem_addr = addr, mem_wdata = enc(corrected data) → IDLE.
- Scrub timer:
  - Counts every cycle while scrub_en = 1 and scrub_pending = 0.
  - At SCRUB_INTERVAL−1: sets scrub_pending and returns to 0.
  - scrub_en = 0 holds the timer at 0; an already-pending scrub is not started.
- All mem_* and host_* outputs are registered. mem_re and mem_we are never high in the same cycle.

## Timing
- Reset: state = IDLE. All outputs, counters, timer, scrub_addr and scrub_pending are 0.
- Reset mid-operation abandons the operation. No mem_we is issued in the cycle after rst, and a pending WB is dropped.
- Host write accepted in cycle T: mem_we and host_wack in T+1; next acceptance possible in T+2.
- Host read accepted in cycle T:
  - mem_re in T+1; decode in T+2; host_rvalid in T+3.
  - Single error: writeback mem_we in T+3.
  - Next acceptance possible in T+3 (clean or double error) or T+4 (single error).
- Scrub occupies 3 cycles (READ, CHECK, IDLE) when clean, or 4 with a writeback.
- If host_req and scrub_pending are both present in IDLE, the host is granted and the scrub waits for the next IDLE cycle with no host_req.
- Counters saturate; they never wrap.

## Test plan
- Write 0x00002108 to address 3, then read address 3 → host_rvalid at T+3, rdata = 0x00002108, both error flags 0, counters unchanged.
- Flip codeword bit 5 of address 3 in the memory model, then read → rdata = 0x00002108, err_single = 1, WB mem_we at T+3 with the clean codeword, corr_count = 1; a re-read is clean.
- Flip bits 2 and 9 of address 7, then read → err_double = 1, no mem_we, uncorr_count = 1, last_err_addr = 7.
- scrub_en = 1, SCRUB_INTERVAL = 8, no host traffic, single error planted at address 0 → scrub read of address 0 ~8 cycles after reset, then a writeback; host_rvalid stays 0; scrub_addr advances to 1; the scrubber wraps from 15 to 0.
- host_req asserted continuously while a scrub is pending → every IDLE grants the host; the scrub starts only after host_req drops.
- Assert rst during the CHECK of a single-error read → no mem_we follows, all outputs 0 the next cycle, counters 0.
